// File: rtl/spi_ram_pkg.sv
// Shared command encodings, FSM state type and width helpers for the SPI RAM slave.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RX_ADDR,
        RX_DATA,
        RD_FETCH,
        TX
    } state_e;

    // Action carried into the cycle after a completed RX frame.
    typedef enum logic [1:0] {
        COMMIT_NONE,
        COMMIT_WR_PTR,
        COMMIT_RD_PTR,
        COMMIT_WRITE
    } commit_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned bits_for(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/spi_ram_slave_if.sv
// Serial bus of the SPI RAM slave; the host side drives ss_n/mosi.
interface spi_ram_slave_if;

    logic ss_n;
    logic mosi;
    logic miso;
    logic frame_err;
    logic busy;

    modport slave (
        input  ss_n,
        input  mosi,
        output miso,
        output frame_err,
        output busy
    );

    modport master (
        output ss_n,
        output mosi,
        input  miso,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM, DATA_WIDTH x MEM_DEPTH; out-of-range writes are
// dropped and out-of-range reads return zero.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned IW = bits_for(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  in_range;
    logic [IW-1:0]         idx;

    // One extra bit keeps the compare correct when MEM_DEPTH == 2**ADDR_WIDTH.
    assign in_range = ((ADDR_WIDTH+1)'(addr) < (ADDR_WIDTH+1)'(MEM_DEPTH));
    assign idx      = IW'(addr);

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = in_range ? mem[idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_slave.sv
// SPI slave (SCK == clk) fronting a single-port RAM with separate write/read pointers.
// Define SPI_RAM_AUTO_INC_EN to post-increment pointers after completed data frames.
module spi_ram_slave
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_slave_if.slave bus
);

    localparam int unsigned PW = max_u(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned CW = bits_for(PW);

    state_e                state_d, state_q;
    commit_e               commit_d, commit_q;
    logic [CW-1:0]         cnt_d, cnt_q;
    logic [1:0]            cmd_d, cmd_q;
    logic [PW-1:0]         sr_d, sr_q;
    logic [DATA_WIDTH-1:0] tx_d, tx_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
    logic                  miso_d, miso_q;
    logic                  frame_err_d, frame_err_q;
    logic                  busy_d, busy_q;

    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

`ifdef SPI_RAM_AUTO_INC_EN
    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction
`endif

    // Writes land in the cycle after RX_DATA, reads only in RD_FETCH, so one port suffices.
    assign mem_we   = (commit_q == COMMIT_WRITE) && !rst;
    assign mem_re   = (state_q == RD_FETCH);
    assign mem_addr = (commit_q == COMMIT_WRITE) ? wr_ptr_q : rd_ptr_q;

    spi_ram_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (sr_q[DATA_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        commit_d    = COMMIT_NONE;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        sr_d        = sr_q;
        tx_d        = tx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        miso_d      = 1'b0;
        frame_err_d = 1'b0;

        // A completed frame commits while the next frame's command is already shifting in.
        case (commit_q)
            COMMIT_WR_PTR: wr_ptr_d = sr_q[ADDR_WIDTH-1:0];
            COMMIT_RD_PTR: rd_ptr_d = sr_q[ADDR_WIDTH-1:0];
`ifdef SPI_RAM_AUTO_INC_EN
            COMMIT_WRITE:  wr_ptr_d = ptr_next(wr_ptr_q);
`endif
            default: ;
        endcase

        if (state_q != IDLE && bus.ss_n) begin
            state_d     = IDLE;
            frame_err_d = !(state_q == CMD && cnt_q == '0);
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.ss_n) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    cmd_d = {cmd_q[0], bus.mosi};
                    if (cnt_q == CW'(1)) begin
                        case (cmd_d)
                            CMD_WR_ADDR, CMD_RD_ADDR: begin
                                state_d = RX_ADDR;
                                cnt_d   = CW'(ADDR_WIDTH - 1);
                            end
                            CMD_WR_DATA: begin
                                state_d = RX_DATA;
                                cnt_d   = CW'(DATA_WIDTH - 1);
                            end
                            default: begin
                                state_d = RD_FETCH;
                                cnt_d   = '0;
                            end
                        endcase
                    end else begin
                        cnt_d = CW'(1);
                    end
                end
                RX_ADDR, RX_DATA: begin
                    sr_d = {sr_q[PW-2:0], bus.mosi};
                    if (cnt_q == '0) begin
                        state_d = CMD;
                        if (state_q == RX_DATA) begin
                            commit_d = COMMIT_WRITE;
                        end else if (cmd_q == CMD_RD_ADDR) begin
                            commit_d = COMMIT_RD_PTR;
                        end else begin
                            commit_d = COMMIT_WR_PTR;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                RD_FETCH: begin
                    state_d = TX;
                    cnt_d   = CW'(DATA_WIDTH - 1);
                end
                TX: begin
                    // RAM output is only valid from the first TX cycle; it seeds the shifter there.
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        miso_d = mem_rdata[DATA_WIDTH-1];
                        tx_d   = mem_rdata << 1;
                    end else begin
                        miso_d = tx_q[DATA_WIDTH-1];
                        tx_d   = tx_q << 1;
                    end
                    if (cnt_q == '0) begin
                        state_d = CMD;
`ifdef SPI_RAM_AUTO_INC_EN
                        rd_ptr_d = ptr_next(rd_ptr_q);
`endif
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            commit_q    <= COMMIT_NONE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            sr_q        <= '0;
            tx_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            commit_q    <= commit_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            sr_q        <= sr_d;
            tx_q        <= tx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            miso_q      <= miso_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_ram_slave.sv
// Scoreboard bench for spi_ram_slave: three instances (depth 200, 4x12 bits, depth 256)
// share one stimulus driver; read frames queue their expected words for the miso monitor.
module tb_spi_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss_n_drv;
    logic        mosi_drv;
    int unsigned sel;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          err_cnt [3];

    typedef struct {
        int unsigned dut;
        int unsigned width;
        logic [15:0] data;
        int unsigned first_cyc;
    } rd_exp_t;

    rd_exp_t exp_q[$];

    spi_ram_slave_if if_a ();
    spi_ram_slave_if if_b ();
    spi_ram_slave_if if_c ();

    assign if_a.ss_n = (sel == 0) ? ss_n_drv : 1'b1;
    assign if_b.ss_n = (sel == 1) ? ss_n_drv : 1'b1;
    assign if_c.ss_n = (sel == 2) ? ss_n_drv : 1'b1;
    assign if_a.mosi = mosi_drv;
    assign if_b.mosi = mosi_drv;
    assign if_c.mosi = mosi_drv;

    spi_ram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200)) u_dut_a (
        .clk (clk), .rst (rst), .bus (if_a)
    );
    spi_ram_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(12), .MEM_DEPTH(16)) u_dut_b (
        .clk (clk), .rst (rst), .bus (if_b)
    );
    spi_ram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256)) u_dut_c (
        .clk (clk), .rst (rst), .bus (if_c)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        err_cnt[0] = 0;
        err_cnt[1] = 0;
        err_cnt[2] = 0;
    end

    always @(negedge clk) begin
        if (if_a.frame_err === 1'b1) err_cnt[0] <= err_cnt[0] + 1;
        if (if_b.frame_err === 1'b1) err_cnt[1] <= err_cnt[1] + 1;
        if (if_c.frame_err === 1'b1) err_cnt[2] <= err_cnt[2] + 1;
    end

    function automatic logic miso_of(input int unsigned d);
        case (d)
            0:       return if_a.miso;
            1:       return if_b.miso;
            default: return if_c.miso;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic tick(input logic b);
        @(negedge clk);
        ss_n_drv = 1'b0;
        mosi_drv = b;
    endtask

    task automatic begin_frame();
        @(negedge clk);
        ss_n_drv = 1'b0;
        mosi_drv = 1'b1;
    endtask

    task automatic end_frame();
        @(negedge clk);
        ss_n_drv = 1'b1;
        mosi_drv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] v, input int unsigned n);
        logic [15:0] t;
        t = v << (16 - n);
        for (int unsigned k = 0; k < n; k++) begin
            tick(t[15]);
            t = t << 1;
        end
    endtask

    task automatic op(input logic [1:0] c, input logic [15:0] payload, input int unsigned n);
        send({14'd0, c}, 2);
        send(payload, n);
    endtask

    // Second cmd bit is sampled at the next edge; first miso bit is visible two edges after it.
    task automatic rd(input int unsigned w, input logic [15:0] expv);
        rd_exp_t e;
        send(16'h0003, 2);
        e.dut       = sel;
        e.width     = w;
        e.data      = expv;
        e.first_cyc = cyc + 3;
        exp_q.push_back(e);
        repeat (w + 1) tick(1'b0);
    endtask

    initial begin : monitor
        rd_exp_t     e;
        logic [15:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0 && cyc >= exp_q[0].first_cyc) begin
                e   = exp_q.pop_front();
                got = '0;
                check("rd_start_cycle", 32'(cyc), 32'(e.first_cyc));
                for (int unsigned k = 0; k < e.width; k++) begin
                    if (k != 0) @(negedge clk);
                    got = {got[14:0], miso_of(e.dut)};
                end
                check("rd_data", 32'(got), 32'(e.data));
                @(negedge clk);
                check("miso_idle_after_rd", 32'(miso_of(e.dut)), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin : driver
        sel      = 0;
        rst      = 1'b1;
        ss_n_drv = 1'b0;
        mosi_drv = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_miso", 32'(if_a.miso), 32'd0);
        check("reset_busy", 32'(if_a.busy), 32'd0);
        check("reset_frame_err", 32'(if_a.frame_err), 32'd0);
        rst      = 1'b0;
        ss_n_drv = 1'b1;
        repeat (2) @(negedge clk);

        // Write then read, several frames per select
        begin_frame();
        op(2'b00, 16'h00, 8);
        op(2'b01, 16'h11, 8);
        check("busy_mid_frame", 32'(if_a.busy), 32'd1);
        op(2'b00, 16'h05, 8);
        op(2'b01, 16'hA5, 8);
        op(2'b10, 16'h05, 8);
        rd(8, 16'h00A5);
        end_frame();
        check("busy_after_frame", 32'(if_a.busy), 32'd0);
        check("clean_end_no_err", 32'(err_cnt[0]), 32'd0);

        // Pointers return to 0 on reset
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin_frame();
        op(2'b01, 16'h5A, 8);
        rd(8, 16'h005A);
        op(2'b10, 16'h05, 8);
        rd(8, 16'h00A5);
        end_frame();

        // Aborts: mid RX_DATA, mid CMD, mid TX
        begin_frame();
        op(2'b00, 16'h05, 8);
        send(16'h0001, 2);
        send(16'h0003, 4);
        end_frame();
        check("abort_rx_err", 32'(err_cnt[0]), 32'd1);
        check("abort_busy", 32'(if_a.busy), 32'd0);
        begin_frame();
        tick(1'b0);
        end_frame();
        check("abort_cmd_err", 32'(err_cnt[0]), 32'd2);
        begin_frame();
        op(2'b10, 16'h05, 8);
        send(16'h0003, 2);
        repeat (4) tick(1'b0);
        end_frame();
        check("abort_tx_err", 32'(err_cnt[0]), 32'd3);
        begin_frame();
        rd(8, 16'h00A5);
        end_frame();
        check("read_end_no_err", 32'(err_cnt[0]), 32'd3);

        // Last in-range word and first out-of-range word (depth 200)
        begin_frame();
        op(2'b00, 16'hC7, 8);
        op(2'b01, 16'h77, 8);
        op(2'b00, 16'hC8, 8);
        op(2'b01, 16'hFF, 8);
        op(2'b10, 16'hC7, 8);
        rd(8, 16'h0077);
        op(2'b10, 16'hC8, 8);
        rd(8, 16'h0000);
        end_frame();

        // Pointer behaviour across consecutive data frames (depth 256)
        sel = 2;
        begin_frame();
        op(2'b00, 16'hFE, 8);
        op(2'b01, 16'h11, 8);
        op(2'b01, 16'h22, 8);
        op(2'b01, 16'h33, 8);
        op(2'b10, 16'hFE, 8);
`ifdef SPI_RAM_AUTO_INC_EN
        rd(8, 16'h0011);
        rd(8, 16'h0022);
        rd(8, 16'h0033);
`else
        rd(8, 16'h0033);
        rd(8, 16'h0033);
        rd(8, 16'h0033);
`endif
        end_frame();
        check("stream_no_err", 32'(err_cnt[2]), 32'd0);

        // Width generality: 4-bit address, 12-bit data
        sel = 1;
        begin_frame();
        op(2'b00, 16'h000F, 4);
        op(2'b01, 16'h0ABC, 12);
        op(2'b00, 16'h0000, 4);
        op(2'b01, 16'h0123, 12);
        op(2'b10, 16'h000F, 4);
        rd(12, 16'h0ABC);
        op(2'b10, 16'h0000, 4);
        rd(12, 16'h0123);
        end_frame();

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
